alu_share_ctrl: RTL and testbench

Sequencer that shares the single combinational execute ALU between two requesters: port 0 is the pipeline EXE stage, port 1 is the secondary address/debug engine. It arbitrates round-robin, registers the winning operands and drives the ALU, captures the result and flags, and returns a one-cycle response. It also owns the architectural NZCV status register, which it updates on flag-setting operations and feeds back as the ALU carry-in.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : alu_pkg
//  Purpose  : Shared definitions for the EXE-stage ALU sharing logic:
//             EXE_CMD encodings, sequencer state type, NZCV bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // EXE_CMD encodings understood by the execute ALU (0 = default, yields 0)
  localparam logic [3:0] MOV = 4'b0001;
  localparam logic [3:0] MVN = 4'b1001;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] ADC = 4'b0011;
  localparam logic [3:0] SUB = 4'b0100;
  localparam logic [3:0] SBC = 4'b0101;
  localparam logic [3:0] AND = 4'b0110;
  localparam logic [3:0] ORR = 4'b0111;
  localparam logic [3:0] EOR = 4'b1000;

  // Sequencer states, explicitly encoded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit positions inside a {N,Z,C,V} nibble
  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-way round-robin arbiter. Grant is one-hot among valid
//             inputs; on contention the port that did not win last time wins.
//             The history bit only moves when the grant is actually taken.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // Index of the most recently accepted port; 1 so port 0 wins first contention
  logic r_last;

  // One-hot grant: single requester wins outright, contention goes to !last
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = r_last ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner only when its request was really accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_ctrl
//  Purpose  : Shares the single EXE-stage ALU between the pipeline (port 0)
//             and the address/debug engine (port 1). Arbitrates, registers
//             operands, drives the ALU for one cycle, captures result and
//             flags, and returns a one-cycle response. Owns the NZCV register
//             and feeds its carry back into the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0][31:0] req_val1,
  input  logic [N_REQ-1:0][31:0] req_val2,
  input  logic [N_REQ-1:0][3:0]  req_cmd,
  input  logic [N_REQ-1:0]       req_s,
  input  logic                   flush,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [31:0]            rsp_result,
  output logic [3:0]             rsp_status,
  output logic [31:0]            alu_val1,
  output logic [31:0]            alu_val2,
  output logic [3:0]             alu_cmd,
  output logic                   alu_c,
  input  logic [31:0]            alu_result,
  input  logic [3:0]             alu_status,
  output logic [3:0]             nzcv
);

  state_t           r_state;
  logic [31:0]      r_val1;
  logic [31:0]      r_val2;
  logic [3:0]       r_cmd;
  logic             r_s;
  logic             r_owner;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic [3:0]       r_rsp_status;
  logic [3:0]       r_nzcv;

  logic [1:0]       w_grant;
  logic             w_accept_state;
  logic             w_accept;
  logic             w_sel;
  logic             w_exec;
  logic             w_abort;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (w_accept),
    .grant  (w_grant)
  );

  // Handshake: accept only between ops; flush holds off the pipeline port.
  // Gated by reset so every output reads zero while reset is held.
  always_comb begin
    w_accept_state = !rst && ((r_state == IDLE) || (r_state == RESP));
    req_ready      = {w_accept_state & w_grant[1],
                      w_accept_state & w_grant[0] & ~flush};
    w_accept       = |(req_valid & req_ready);
    w_sel          = req_ready[1];
    w_exec         = (r_state == EXEC);
    w_abort        = w_exec && !r_owner && flush;
  end

  // ALU sees the held operands only while executing, zeros otherwise
  always_comb begin
    alu_val1 = w_exec ? r_val1 : 32'd0;
    alu_val2 = w_exec ? r_val2 : 32'd0;
    alu_cmd  = w_exec ? r_cmd  : 4'd0;
    alu_c    = r_nzcv[NZCV_C];
  end

  // Sequencer: accept -> EXEC -> RESP, with flush abort of pipeline ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_val1       <= 32'd0;
      r_val2       <= 32'd0;
      r_cmd        <= 4'd0;
      r_s          <= 1'b0;
      r_owner      <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_result <= 32'd0;
      r_rsp_status <= 4'd0;
      r_nzcv       <= 4'd0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_state <= EXEC;
            r_val1  <= req_val1[w_sel];
            r_val2  <= req_val2[w_sel];
            r_cmd   <= req_cmd[w_sel];
            r_s     <= req_s[w_sel];
            r_owner <= w_sel;
          end else begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else begin
            r_state      <= RESP;
            r_rsp_result <= alu_result;
            r_rsp_status <= alu_status;
            r_rsp_valid  <= {r_owner, ~r_owner};
            if (r_s) begin
              r_nzcv <= alu_status;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_status = r_rsp_status;
  assign nzcv       = r_nzcv;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_ctrl
//  Purpose  : Self-checking bench for alu_share_ctrl with a behavioural ALU
//             and a sequential-execution reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][31:0] req_val1;
  logic [1:0][31:0] req_val2;
  logic [1:0][3:0] req_cmd;
  logic [1:0]      req_s;
  logic            flush;
  logic [1:0]      rsp_valid;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_status;
  logic [31:0]     alu_val1;
  logic [31:0]     alu_val2;
  logic [3:0]      alu_cmd;
  logic            alu_c;
  logic [31:0]     alu_result;
  logic [3:0]      alu_status;
  logic [3:0]      nzcv;

  int   tests = 0;
  int   fails = 0;
  logic model_last;
  logic [3:0] model_nzcv;

  alu_share_ctrl #(.N_REQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_val1   (req_val1),
    .req_val2   (req_val2),
    .req_cmd    (req_cmd),
    .req_s      (req_s),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .alu_val1   (alu_val1),
    .alu_val2   (alu_val2),
    .alu_cmd    (alu_cmd),
    .alu_c      (alu_c),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .nzcv       (nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM-style ALU: returns {N,Z,C,V, result}
  function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      MOV: r = b;
      MVN: r = ~b;
      ADD, ADC: begin
        w = {1'b0, a} + {1'b0, b} + ((cmd == ADC) ? {32'd0, cin} : 33'd0);
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, SBC: begin
        w = {1'b0, a} + {1'b0, ~b} + ((cmd == SUB) ? 33'd1 : {32'd0, cin});
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AND: r = a & b;
      ORR: r = a | b;
      EOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_status, alu_result} = alu_ref(alu_cmd, alu_val1, alu_val2, alu_c);

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Present a request on port p and hold it until accepted (bounded)
  task automatic send(input int p, input logic [3:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic s, output logic ok, output int waits);
    req_valid[p] = 1'b1; req_cmd[p] = cmd; req_val1[p] = a; req_val2[p] = b; req_s[p] = s;
    ok = 1'b0; waits = 0;
    while (!ok && waits < 20) begin
      #1;
      if (req_ready[p]) ok = 1'b1; else waits++;
      tick();
    end
    req_valid[p] = 1'b0;
  endtask

  // Reference: ops execute in acceptance order, each seeing flags of the previous ones
  task automatic model_op(input int p, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          output logic [31:0] er, output logic [3:0] es);
    {es, er} = alu_ref(cmd, a, b, model_nzcv[1]);
    if (s) model_nzcv = es;
    model_last = (p == 1);
  endtask

  function automatic logic [31:0] rnd_opnd();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom);
  endfunction

  task automatic test_reset;
    rst = 1'b1; req_valid = 2'b11;
    tick(); tick(); #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    tests++; if ({rsp_result, rsp_status} !== 36'd0) begin fails++; $display("FAIL reset_rsp_data: got %h/%b want 0", rsp_result, rsp_status); end
    tests++; if (nzcv !== 4'b0000) begin fails++; $display("FAIL reset_nzcv: got %b want 0000", nzcv); end
    tests++; if ({alu_val1, alu_val2, alu_cmd, alu_c} !== 69'd0) begin fails++; $display("FAIL reset_alu: got %h %h %h %b want 0", alu_val1, alu_val2, alu_cmd, alu_c); end
    req_valid = 2'b00; rst = 1'b0;
    model_last = 1'b1; model_nzcv = 4'b0000;
    tick();
  endtask

  task automatic test_single_add;
    logic ok; int w; logic [31:0] er; logic [3:0] es;
    send(0, ADD, 32'd5, 32'd3, 1'b1, ok, w);
    model_op(0, ADD, 32'd5, 32'd3, 1'b1, er, es);
    tests++; if (!(ok && w == 0)) begin fails++; $display("FAIL add_ready_same_cycle: got ok=%b waits=%0d want ok=1 waits=0", ok, w); end
    #1;
    tests++; if ({alu_cmd, alu_val1, alu_val2} !== {ADD, 32'd5, 32'd3}) begin fails++; $display("FAIL add_alu_drive: got %h %h %h want 2 5 3", alu_cmd, alu_val1, alu_val2); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL add_exec_no_rsp: got %b want 00", rsp_valid); end
    tick(); #1;
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
    tests++; if (rsp_result !== 32'd8 || rsp_result !== er) begin fails++; $display("FAIL add_result: got %h want 8", rsp_result); end
    tests++; if (nzcv !== 4'b0000 || nzcv !== model_nzcv) begin fails++; $display("FAIL add_nzcv: got %b want 0000", nzcv); end
    tick(); #1;
    tests++; if (rsp_valid !== 2'b00 || rsp_result !== 32'd8) begin fails++; $display("FAIL add_rsp_hold: got %b/%h want 00/8", rsp_valid, rsp_result); end
    tick();
  endtask

  task automatic test_flags;
    logic ok; int w; logic [31:0] er; logic [3:0] es;
    send(0, ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, ok, w);
    model_op(0, ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, er, es);
    tick(); #1;
    tests++; if (!ok || rsp_valid !== 2'b01 || rsp_result !== 32'h8000_0000) begin fails++; $display("FAIL ovf_result: got ok=%b %b %h want 01 80000000", ok, rsp_valid, rsp_result); end
    tests++; if (nzcv !== 4'b1001 || rsp_status !== 4'b1001) begin fails++; $display("FAIL ovf_nzcv: got %b/%b want 1001", nzcv, rsp_status); end
    send(1, ADC, 32'd1, 32'd1, 1'b0, ok, w);
    model_op(1, ADC, 32'd1, 32'd1, 1'b0, er, es);
    #1;
    tests++; if (!(ok && w == 0) || alu_c !== 1'b0) begin fails++; $display("FAIL adc_carry_in: got ok=%b waits=%0d c=%b want 1 0 0", ok, w, alu_c); end
    tick(); #1;
    tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd2 || rsp_result !== er) begin fails++; $display("FAIL adc_result: got %b %h want 10 2", rsp_valid, rsp_result); end
    send(0, SUB, 32'd4, 32'd4, 1'b0, ok, w);
    model_op(0, SUB, 32'd4, 32'd4, 1'b0, er, es);
    tick(); #1;
    tests++; if (!ok || rsp_result !== 32'd0 || rsp_status[NZCV_Z] !== 1'b1 || rsp_status !== es) begin fails++; $display("FAIL sub_nos_result: got %h %b want 0 %b", rsp_result, rsp_status, es); end
    tests++; if (nzcv !== 4'b1001 || nzcv !== model_nzcv) begin fails++; $display("FAIL sub_nos_nzcv: got %b want 1001", nzcv); end
    tick();
  endtask

  task automatic test_flush;
    logic ok; int w; logic [31:0] er; logic [3:0] es;
    flush = 1'b1;
    req_valid[0] = 1'b1; req_cmd[0] = MOV; req_val1[0] = 32'd0; req_val2[0] = 32'd7; req_s[0] = 1'b1;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL flush_blocks_port0: got %b want 00", req_ready); end
    tick();
    flush = 1'b0;
    send(0, MOV, 32'd0, 32'd7, 1'b1, ok, w);
    model_last = 1'b0;
    tests++; if (!(ok && w == 0)) begin fails++; $display("FAIL flush_mov_accept: got ok=%b waits=%0d want 1 0", ok, w); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid[1] = 1'b1; req_cmd[1] = ORR; req_val1[1] = 32'h00F0; req_val2[1] = 32'h0F00; req_s[1] = 1'b0;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL port1_after_flush: got %b want 10", req_ready); end
    tests++; if (rsp_valid !== 2'b00 || nzcv !== model_nzcv) begin fails++; $display("FAIL flush_no_effect: got rsp=%b nzcv=%b want 00 %b", rsp_valid, nzcv, model_nzcv); end
    tick();
    req_valid[1] = 1'b0;
    model_op(1, ORR, 32'h00F0, 32'h0F00, 1'b0, er, es);
    flush = 1'b1;
    #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL flush_exec_p1_early: got %b want 00", rsp_valid); end
    tick(); #1;
    tests++; if (rsp_valid !== 2'b10 || rsp_result !== er || nzcv !== model_nzcv) begin fails++; $display("FAIL flush_spares_port1: got %b %h %b want 10 %h %b", rsp_valid, rsp_result, nzcv, er, model_nzcv); end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_res;
    logic [3:0]  exp_st, exp_nz;
    logic [1:0]  exp_rv, exp_ready, refresh;
    logic        can_acc;
    int          due, accepts, p;
    for (int i = 0; i < 2; i++) begin
      req_cmd[i] = 4'($urandom_range(1, 9)); req_val1[i] = rnd_opnd();
      req_val2[i] = rnd_opnd(); req_s[i] = 1'($urandom_range(0, 1));
    end
    can_acc = 1'b1; due = -1; accepts = 0;
    exp_res = '0; exp_st = '0; exp_nz = '0; exp_rv = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (accepts >= 16 && due < cyc) break;
      req_valid = (accepts < 16) ? 2'b11 : 2'b00;
      #1;
      tests++;
      if (due == cyc) begin
        if ({rsp_valid, rsp_result, rsp_status, nzcv} !== {exp_rv, exp_res, exp_st, exp_nz}) begin
          fails++;
          $display("FAIL b2b_rsp cyc%0d: got %b %h %b %b want %b %h %b %b", cyc, rsp_valid, rsp_result, rsp_status, nzcv, exp_rv, exp_res, exp_st, exp_nz);
        end
      end else if (rsp_valid !== 2'b00) begin
        fails++; $display("FAIL b2b_spurious_rsp cyc%0d: got %b want 00", cyc, rsp_valid);
      end
      exp_ready = (can_acc && accepts < 16) ? (model_last ? 2'b01 : 2'b10) : 2'b00;
      tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL b2b_grant cyc%0d: got %b want %b", cyc, req_ready, exp_ready); end
      refresh = 2'b00;
      if (exp_ready != 2'b00) begin
        p = model_last ? 0 : 1;
        model_op(p, req_cmd[p], req_val1[p], req_val2[p], req_s[p], exp_res, exp_st);
        exp_nz = model_nzcv; exp_rv = (p == 1) ? 2'b10 : 2'b01;
        due = cyc + 2; accepts++; can_acc = 1'b0; refresh[p] = 1'b1;
      end else begin
        can_acc = 1'b1;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        if (refresh[i]) begin
          req_cmd[i] = 4'($urandom_range(1, 9)); req_val1[i] = rnd_opnd();
          req_val2[i] = rnd_opnd(); req_s[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_exec;
    logic ok; int w; logic [31:0] er; logic [3:0] es;
    send(1, SUB, 32'd1, 32'd2, 1'b1, ok, w);
    model_op(1, SUB, 32'd1, 32'd2, 1'b1, er, es);
    tick();
    send(0, ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, ok, w);
    tests++; if (!ok || nzcv !== 4'b1000 || rsp_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL pre_reset_state: got ok=%b %b %h want 1 1000 ffffffff", ok, nzcv, rsp_result); end
    #1;
    rst = 1'b1; req_valid = 2'b11;
    #1;
    tests++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin fails++; $display("FAIL rst_exec_handshake: got %b %b want 00 00", rsp_valid, req_ready); end
    tests++; if ({rsp_result, rsp_status, nzcv} !== 40'd0) begin fails++; $display("FAIL rst_exec_data: got %h %b %b want 0", rsp_result, rsp_status, nzcv); end
    tests++; if ({alu_val1, alu_val2, alu_cmd, alu_c} !== 69'd0) begin fails++; $display("FAIL rst_exec_alu: got %h %h %h %b want 0", alu_val1, alu_val2, alu_cmd, alu_c); end
    tick();
    req_valid = 2'b00; rst = 1'b0;
    model_nzcv = 4'b0000; model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL rst_no_late_rsp %0d: got %b want 00", i, rsp_valid); end
      tick();
    end
    req_cmd[0] = EOR; req_val1[0] = 32'hA5A5_0000; req_val2[0] = 32'h0000_5A5A; req_s[0] = 1'b1;
    req_cmd[1] = AND; req_val1[1] = 32'hFFFF; req_val2[1] = 32'h00FF; req_s[1] = 1'b1;
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rst_last_is_1: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    model_op(0, EOR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, er, es);
    tick(); #1;
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== er || nzcv !== model_nzcv) begin fails++; $display("FAIL rst_post_op: got %b %h %b want 01 %h %b", rsp_valid, rsp_result, nzcv, er, model_nzcv); end
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 2'b00; req_s = 2'b00;
    req_val1 = '0; req_val2 = '0; req_cmd = '0;
    model_last = 1'b1; model_nzcv = 4'b0000;
    test_reset();
    test_single_add();
    test_flags();
    test_flush();
    test_back_to_back();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
